// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU codes,
// sequencer state encoding and opcode classes.
package minisrc_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_PAUSE, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_RALU, CLS_IMM, CLS_MULDIV, CLS_UNARY,
    CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } op_class_e;

endpackage

// File: rtl/minisrc_op_class.sv
// Combinational opcode-to-class decode; reserved opcodes fall into NOP.
module minisrc_op_class
  import minisrc_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class
);

  // Map each opcode (or opcode range) to the execute sequence it follows
  always_comb begin
    op_class = CLS_NOP;
    case (opcode) inside
      OP_LD:                 op_class = CLS_LD;
      OP_LDI:                op_class = CLS_LDI;
      OP_ST:                 op_class = CLS_ST;
      [OP_ADD:OP_SHL]:       op_class = CLS_RALU;
      [OP_ADDI:OP_ORI]:      op_class = CLS_IMM;
      OP_DIV, OP_MUL:        op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:        op_class = CLS_UNARY;
      OP_BR:                 op_class = CLS_BR;
      OP_JR:                 op_class = CLS_JR;
      OP_IN:                 op_class = CLS_IN;
      OP_OUT:                op_class = CLS_OUT;
      OP_MFHI:               op_class = CLS_MFHI;
      OP_MFLO:               op_class = CLS_MFLO;
      OP_HALT:               op_class = CLS_HALT;
      default:               op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired control sequencer for the Mini SRC: fetch in T0-T2, then an
// opcode-dependent execute sequence in T3-T7, one step per clock.
module minisrc_control_unit
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        Stop,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  output logic        Run,
  output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in,
  output logic        MAR_in, MDR_in, OutPort_in, IncPC,
  output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
  output logic        MDR_out, InPort_out, C_out,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [4:0]  alu_instruction_bits
);

  state_e         state_q, state_d;
  logic           con_q, con_d;
  logic           last_step;
  logic [OPW-1:0] opcode;
  logic [4:0]     imm_alu;
  op_class_e      op_class;
  logic           unused_ir_bits;

  assign opcode         = IR_Data[31:27];
  assign unused_ir_bits = ^IR_Data[26:0];

  minisrc_op_class u_op_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // Immediate ops reuse the ALU code of their register-form counterpart
  always_comb begin
    imm_alu = ALU_ADD;
    case (opcode)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
  end

  // State register and branch-condition latch; clr abandons any instruction
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RESET;
      con_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      con_q   <= con_d;
    end
  end

  // Next-state and strobe decode from the registered state and opcode class
  always_comb begin
    state_d = state_q;
    con_d = con_q;
    last_step = 1'b0;
    Run = (state_q != ST_PAUSE) && (state_q != ST_HALT);
    PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0;
    HI_in = 1'b0; LO_in = 1'b0; MAR_in = 1'b0; MDR_in = 1'b0;
    OutPort_in = 1'b0; IncPC = 1'b0;
    PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0;
    LO_out = 1'b0; MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_instruction_bits = 5'b00000;

    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (op_class)
          CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
          CLS_RALU, CLS_IMM:       begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          CLS_MULDIV:              begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          CLS_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opcode;
          end
          CLS_BR:   begin Gra = 1'b1; Rout = 1'b1; con_d = CON_out; end
          CLS_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; last_step = 1'b1; end
          CLS_IN:   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; last_step = 1'b1; end
          CLS_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          CLS_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          CLS_HALT: state_d = ST_HALT;
          default:  last_step = 1'b1;
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (op_class)
          CLS_LD, CLS_LDI, CLS_ST: begin
            C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD;
          end
          CLS_RALU, CLS_MULDIV: begin
            Grc = (op_class == CLS_RALU); Grb = (op_class == CLS_MULDIV);
            Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opcode;
          end
          CLS_IMM:   begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = imm_alu; end
          CLS_UNARY: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          CLS_BR:    begin PC_out = 1'b1; Y_in = 1'b1; end
          default:   last_step = 1'b1;
        endcase
      end
      ST_T5: begin
        state_d = ST_T6;
        case (op_class)
          CLS_LD, CLS_ST:             begin Zlow_out = 1'b1; MAR_in = 1'b1; end
          CLS_LDI, CLS_RALU, CLS_IMM: begin
            Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
          end
          CLS_MULDIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
          CLS_BR: begin
            C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T6: begin
        state_d = ST_T7;
        case (op_class)
          CLS_LD:     begin Read = 1'b1; MDR_in = 1'b1; end
          CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
          CLS_MULDIV: begin Zhigh_out = 1'b1; HI_in = 1'b1; last_step = 1'b1; end
          CLS_BR:     begin Zlow_out = 1'b1; PC_in = con_q; last_step = 1'b1; end
          default:    last_step = 1'b1;
        endcase
      end
      ST_T7: begin
        last_step = 1'b1;
        case (op_class)
          CLS_LD:  begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_ST:  Write = 1'b1;
          default: ;
        endcase
      end
      ST_PAUSE: if (!Stop) state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase

    if (last_step) state_d = Stop ? ST_PAUSE : ST_T0;
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Directed testbench for minisrc_control_unit: walks instructions through
// the sequencer and compares the full strobe vector every cycle.
module tb_minisrc_control_unit;

  logic        clk, clr, Stop, CON_out;
  logic [31:0] IR_Data;
  logic        Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
  logic        OutPort_in, IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out;
  logic        MDR_out, InPort_out, C_out, Read, Write;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_instruction_bits;
  logic [31:0] outVec;

  int errorCount = 0;
  int checkCount = 0;
  logic [31:0] expSeq [0:7];

  localparam logic [31:0] RUN   = 32'h8000_0000;
  localparam logic [31:0] PCIN  = 32'h1 << 30;
  localparam logic [31:0] IRIN  = 32'h1 << 29;
  localparam logic [31:0] YIN   = 32'h1 << 28;
  localparam logic [31:0] ZIN   = 32'h1 << 27;
  localparam logic [31:0] HIIN  = 32'h1 << 26;
  localparam logic [31:0] LOIN  = 32'h1 << 25;
  localparam logic [31:0] MARIN = 32'h1 << 24;
  localparam logic [31:0] MDRIN = 32'h1 << 23;
  localparam logic [31:0] OUTPIN= 32'h1 << 22;
  localparam logic [31:0] INCPC = 32'h1 << 21;
  localparam logic [31:0] PCOUT = 32'h1 << 20;
  localparam logic [31:0] ZHIGH = 32'h1 << 19;
  localparam logic [31:0] ZLOW  = 32'h1 << 18;
  localparam logic [31:0] HIOUT = 32'h1 << 17;
  localparam logic [31:0] LOOUT = 32'h1 << 16;
  localparam logic [31:0] MDROUT= 32'h1 << 15;
  localparam logic [31:0] INPOUT= 32'h1 << 14;
  localparam logic [31:0] COUT  = 32'h1 << 13;
  localparam logic [31:0] READ  = 32'h1 << 12;
  localparam logic [31:0] WRITE = 32'h1 << 11;
  localparam logic [31:0] GRA   = 32'h1 << 10;
  localparam logic [31:0] GRB   = 32'h1 << 9;
  localparam logic [31:0] GRC   = 32'h1 << 8;
  localparam logic [31:0] RIN   = 32'h1 << 7;
  localparam logic [31:0] ROUT  = 32'h1 << 6;
  localparam logic [31:0] BAOUT = 32'h1 << 5;

  localparam logic [31:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [31:0] F1 = RUN | ZLOW | PCIN | READ | MDRIN;
  localparam logic [31:0] F2 = RUN | MDROUT | IRIN;

  assign outVec = {Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
                   OutPort_in, IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
                   MDR_out, InPort_out, C_out, Read, Write,
                   Gra, Grb, Grc, Rin, Rout, BAout, alu_instruction_bits};

  minisrc_control_unit dut (
    .clk(clk), .clr(clr), .Stop(Stop), .IR_Data(IR_Data), .CON_out(CON_out),
    .Run(Run), .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
    .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .OutPort_in(OutPort_in), .IncPC(IncPC), .PC_out(PC_out),
    .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out),
    .C_out(C_out), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_instruction_bits(alu_instruction_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if the observed vector differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Step an instruction from T0 for n cycles, checking each against expSeq
  task automatic runInstr(input string tag, input logic [31:0] ir,
                          input int n, input logic stopAtEnd);
    expSeq[0] = F0; expSeq[1] = F1; expSeq[2] = F2;
    IR_Data = ir;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_c%0d", tag, i + 1), outVec, expSeq[i]);
      if (i == n - 1) Stop = stopAtEnd;
      applyStimulus();
    end
  endtask

  initial begin
    clr = 1'b1; Stop = 1'b0; CON_out = 1'b0; IR_Data = 32'h0;
    applyStimulus();
    checkOutput("reset", outVec, RUN);
    clr = 1'b0;
    applyStimulus();

    // ld: 8 cycles, Rin only in the last
    expSeq[3] = RUN | GRB | BAOUT | YIN;
    expSeq[4] = RUN | COUT | ZIN | 32'd3;
    expSeq[5] = RUN | ZLOW | MARIN;
    expSeq[6] = RUN | READ | MDRIN;
    expSeq[7] = RUN | MDROUT | GRA | RIN;
    runInstr("ld", 32'h0080_0075, 8, 1'b0);

    // add: ALU code 00011 with Grc in T4
    expSeq[3] = RUN | GRB | ROUT | YIN;
    expSeq[4] = RUN | GRC | ROUT | ZIN | 32'd3;
    expSeq[5] = RUN | ZLOW | GRA | RIN;
    runInstr("add", 32'h1800_0000, 6, 1'b0);

    // st: Write only at T7, no Read in execute
    expSeq[3] = RUN | GRB | BAOUT | YIN;
    expSeq[4] = RUN | COUT | ZIN | 32'd3;
    expSeq[5] = RUN | ZLOW | MARIN;
    expSeq[6] = RUN | GRA | ROUT | MDRIN;
    expSeq[7] = RUN | WRITE;
    runInstr("st", 32'h1000_0000, 8, 1'b0);

    // andi: immediate form maps to AND code 00101
    expSeq[3] = RUN | GRB | ROUT | YIN;
    expSeq[4] = RUN | COUT | ZIN | 32'd5;
    expSeq[5] = RUN | ZLOW | GRA | RIN;
    runInstr("andi", 32'h6800_0000, 6, 1'b0);

    // mul: LO then HI writeback, 7 cycles
    expSeq[3] = RUN | GRA | ROUT | YIN;
    expSeq[4] = RUN | GRB | ROUT | ZIN | 32'd16;
    expSeq[5] = RUN | ZLOW | LOIN;
    expSeq[6] = RUN | ZHIGH | HIIN;
    runInstr("mul", 32'h8000_0000, 7, 1'b0);

    // neg: 5 cycles
    expSeq[3] = RUN | GRB | ROUT | ZIN | 32'd17;
    expSeq[4] = RUN | ZLOW | GRA | RIN;
    runInstr("neg", 32'h8800_0000, 5, 1'b0);

    // branch taken: CON_out=1 during T3
    CON_out = 1'b1;
    expSeq[3] = RUN | GRA | ROUT;
    expSeq[4] = RUN | PCOUT | YIN;
    expSeq[5] = RUN | COUT | ZIN | 32'd3;
    expSeq[6] = RUN | ZLOW | PCIN;
    runInstr("brT", 32'h9800_0000, 7, 1'b0);

    // branch not taken: PC_in withheld, Zlow_out still driven
    CON_out = 1'b0;
    expSeq[6] = RUN | ZLOW;
    runInstr("brN", 32'h9800_0000, 7, 1'b0);

    // mfhi and reserved jal (acts as nop): 4 cycles each
    expSeq[3] = RUN | HIOUT | GRA | RIN;
    runInstr("mfhi", 32'hC000_0000, 4, 1'b0);
    expSeq[3] = RUN;
    runInstr("jal", 32'hA800_0000, 4, 1'b0);

    // clr during T4 of ld: abandon to RESET
    expSeq[3] = RUN | GRB | BAOUT | YIN;
    runInstr("ldabort", 32'h0080_0075, 4, 1'b0);
    checkOutput("ldabort_t4", outVec, RUN | COUT | ZIN | 32'd3);
    clr = 1'b1;
    applyStimulus();
    checkOutput("abort_reset", outVec, RUN);
    clr = 1'b0;
    applyStimulus();

    // Stop at T7 of ld: PAUSE until Stop drops
    expSeq[4] = RUN | COUT | ZIN | 32'd3;
    expSeq[5] = RUN | ZLOW | MARIN;
    expSeq[6] = RUN | READ | MDRIN;
    expSeq[7] = RUN | MDROUT | GRA | RIN;
    runInstr("ldstop", 32'h0080_0075, 8, 1'b1);
    checkOutput("pause1", outVec, 32'h0);
    applyStimulus();
    checkOutput("pause2", outVec, 32'h0);
    Stop = 1'b0;
    applyStimulus();

    // halt: idle with Run=0 until clr
    expSeq[3] = RUN;
    runInstr("halt", 32'hD800_0000, 4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("halt_idle%0d", i), outVec, 32'h0);
      applyStimulus();
    end
    clr = 1'b1;
    applyStimulus();
    checkOutput("halt_reset", outVec, RUN);
    clr = 1'b0;
    applyStimulus();
    checkOutput("halt_t0", outVec, F0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/minisrc_control_unit.md
Name: minisrc_control_unit

Overview:
- Hardwired control-sequencer FSM for the Mini SRC CPU. It sits directly upstream of `datapath` and drives every datapath control strobe.
- Steps through fetch (T0–T2), then an opcode-dependent execute sequence (T3–T7), one step per clock.
- Consumes `IR_Data` and `CON_out` from the datapath.
- Replaces hand-timed testbench stimulus with cycle-accurate sequencing.

Parameters:
- OPW, 5, opcode width, taken from IR[31:27].
- ALU_ADD, 5'b00011, ALU code for address and branch-target arithmetic.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset; synchronous, active-high.
- Stop  in  1  pause request, honoured only at an instruction boundary.
- IR_Data  in  32  current instruction register contents.
- CON_out  in  1  branch-condition result from the datapath CON logic.
- Run  out  1  1 while executing; 0 in HALT or PAUSE.
- PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC  out  1 each  register load strobes.
- PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out  out  1 each  bus drive strobes.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls.
- alu_instruction_bits  out  5  ALU operation code.

Behaviour:

States and transitions:
- States: RESET, T0..T7, PAUSE, HALT.
- clr=1 at a rising edge → RESET next cycle, from any state including mid-instruction. The partial instruction is abandoned with no further strobes.
- RESET → T0.
- Instruction end → T0, or → PAUSE if Stop=1 that cycle.
- PAUSE → T0 when Stop=0.
- Illegal/reserved opcodes (jal 10101, 11100–11111) behave as nop.

Output rules:
- All outputs are a combinational decode of the registered state and IR[31:27]. Outputs are 0 unless listed for a step.
- In RESET, PAUSE and HALT all strobes are 0 and alu_instruction_bits=0.
- Run=1 in RESET and T0..T7; Run=0 in PAUSE and HALT.

Fetch (all opcodes):
- T0: PC_out, MAR_in, IncPC, Z_in.
- T1: Zlow_out, PC_in, Read, MDR_in.
- T2: MDR_out, IR_in.

ALU code rules:
- R-format, mul, div, neg, not: alu_instruction_bits = opcode.
- addi → 00011, andi → 00101, ori → 00110.

Execute sequences (step list ends with "end" at the final step):
- ld (00000): T3 Grb BAout Y_in; T4 C_out ALU_ADD Z_in; T5 Zlow_out MAR_in; T6 Read MDR_in; T7 MDR_out Gra Rin, end.
- ldi (00001): T3–T4 as ld; T5 Zlow_out Gra Rin, end.
- st (00010): T3–T5 as ld; T6 Gra Rout MDR_in (Read=0); T7 Write, end.
- R-format ALU (00011–01011): T3 Grb Rout Y_in; T4 Grc Rout Z_in; T5 Zlow_out Gra Rin, end.
- Immediate (01100–01110): T3 Grb Rout Y_in; T4 C_out Z_in; T5 Zlow_out Gra Rin, end.
- div/mul (01111, 10000): T3 Gra Rout Y_in; T4 Grb Rout Z_in; T5 Zlow_out LO_in; T6 Zhigh_out HI_in, end.
- neg/not (10001, 10010): T3 Grb Rout Z_in; T4 Zlow_out Gra Rin, end.
- branch (10011):
  - T3 Gra Rout; CON_out is registered into con_q at the end of T3.
  - T4 PC_out Y_in.
  - T5 C_out ALU_ADD Z_in.
  - T6 Zlow_out, with PC_in asserted only if con_q=1, end.
- jr (10100): T3 Gra Rout PC_in, end.
- in (10110): T3 InPort_out Gra Rin, end.
- out (10111): T3 Gra Rout OutPort_in, end.
- mfhi (11000): T3 HI_out Gra Rin, end.
- mflo (11001): T3 LO_out Gra Rin, end.
- nop (11010): T3 no strobes, end.
- halt (11011): T3 → HALT; held until clr.

Latency and sampling:
- Per-instruction latency: ld / st 8 cycles; ldi / ALU 6; mul / div / branch 7; neg / not 5; jr / in / out / mf* / nop 4.
- IR_Data is sampled combinationally only in T3..T7. It is stable there because IR_in fires only in T2.

Decomposition:
- Shared package `minisrc_pkg`: opcode localparams (OP_LD … OP_HALT), ALU code constants, state enum encoding.
- One sub-module, `minisrc_op_class`: combinational opcode → class decode. Classes: LD, LDI, ST, RALU, IMM, MULDIV, UNARY, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT.

Test Plan:
- Reset then IR_Data=0x00800075 (ld): strobe pattern as specified in T0..T7; Rin=1 only in cycle 8; state=T0 in cycle 9.
- IR_Data=0x18000000 (add): T4 has alu_instruction_bits=00011, Grc=1, Rout=1, Z_in=1; Rin=1 at T5; T0 at cycle 7.
- IR_Data=0x10000000 (st): Write=1 only at T7; Read=0 throughout T3..T7.
- Branch opcode 10011 with CON_out=1 at T3 → PC_in=1 at T6. Repeat with CON_out=0 → PC_in=0 at T6, Zlow_out still 1.
- halt (0xD8000000): Run=0 from cycle 5 and all strobes 0 for 20 cycles. Then clr=1 for one cycle → RESET, then T0.
- clr asserted during T4 of ld → next cycle RESET with all strobes 0. Separately, Stop=1 at T7 of ld → PAUSE, no strobes; Stop=0 → T0.
